div_freq_multi: RTL and testbench
=================================

# div_freq_multi

Parametrised multi-channel clock divider and tick generator. It is the successor to the fixed two-output divider and sits at the top level beside the system clock. Each of NCH channels produces a square-wave enable and a single-cycle tick. Every channel's half-period is programmable at run time through a glitch-free shadowed write port, and the channels can be phase-aligned with a global sync.

## Interface
Parameters:
- NCH, 2, number of channels (≥1).
- CW, 28, width of each divisor and counter.
- DIV_INIT, {28'd25_000_000, 28'd25_000}, packed NCH×CW reset divisors; channel i uses bits [i*CW +: CW].
- CHW (localparam), max(1, ceil(log2 NCH)), width of the channel select.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global count enable; when low, all counters freeze.
- sync  in  1  synchronous restart of all channels in phase.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  CHW  channel to write.
- cfg_div  in  CW  new half-period D.
- sq  out  NCH  per-channel square wave, registered.
- tick  out  NCH  per-channel single-cycle pulse, registered.

## Operation
- Per-channel state:
  - cnt[CW], counter.
  - div_act[CW], active divisor.
  - div_pend[CW], shadow divisor.
  - sq and tick bits.
- Reset (async, while rst=1):
  - cnt=0, sq=0, tick=0.
  - div_act = div_pend = DIV_INIT slice.
- Count rule (en=1, sync=0, div_act=D≠0):
  - If cnt==D-1: cnt←0, sq←~sq, tick←1, div_act←div_pend.
  - Otherwise: cnt←cnt+1, tick←0.
- Resulting frequencies:
  - Half-period is exactly D cycles, so sq period is 2D cycles and tick period is D cycles.
  - D=1 gives sq=clk/2 with tick held at 1.
- Disabled channel (div_act==0):
  - cnt held at 0, sq holds its value, tick=0.
  - div_act←div_pend every cycle, so a nonzero write takes effect immediately.
- en=0: cnt, sq and div_act hold. tick←0.
- sync=1 (overrides en):
  - All channels: cnt←0, tick←0, sq←0, div_act←div_pend.
- Config write (cfg_we=1):
  - div_pend[cfg_ch]←cfg_div.
  - div_act changes only at that channel's next terminal count or at sync, so no runt pulses occur.
  - cfg_ch≥NCH: the write is ignored.
  - Writing 0 stops the channel after its current half-period completes.
- Simultaneous write and terminal count on the same channel:
  - The terminal loads the old div_pend.
  - The new value becomes active at the following terminal.
- Arithmetic:
  - Comparison is against D-1 computed in CW bits.
  - cnt never exceeds D-1, so no wrap-around occurs.
  - Max D = 2^CW-1.

## Timing
- All outputs are registered with no combinational path from inputs.
- From rst release or sync (at edge k) with en=1 held: the first sq rise and tick pulse occur at edge k+D.
- tick is high for exactly one cycle per sq toggle, coincident with the sq edge.
- Config latency:
  - At most D_old cycles to take effect.
  - 1 cycle if the channel is disabled.
  - 1 cycle if sync is asserted on the next cycle or later.
- en deassert/reassert: the counting phase resumes exactly where it froze. Cycles with en=0 are not counted.
- Reset mid-operation: all outputs clear immediately (asynchronously); programmed divisors revert to DIV_INIT.

## Test plan
- Reset/default:
  - Setup: NCH=2, CW=8, DIV_INIT={8'd5,8'd3}; release rst with en=1.
  - ch0: tick at cycles 3,6,9; sq toggles on those edges (period 6).
  - ch1: tick at cycles 5,10 (sq period 10).
  - All outputs must be 0 during reset.
- Shadowed reprogram:
  - Stimulus: write ch0=7 at cycle 4.
  - Cycle 6 toggle still uses D=3; subsequent toggles fall at 13, 20.
  - No sq pulse may be shorter than 3 cycles.
- Disable/enable:
  - Write ch1=0: sq1 freezes after the current half-period and tick1 stays 0.
  - Then write ch1=2: the channel starts counting next cycle and ticks every 2 cycles.
- Global enable:
  - Hold en=0 for 4 cycles mid-count.
  - cnt, sq and tick stay frozen/0; the next tick is delayed by exactly 4 cycles.
- Sync alignment:
  - Stimulus: pulse sync at an arbitrary cycle k.
  - Both sq go to 0; pending divisors load.
  - ch0 toggles at k+3, ch1 at k+5.
  - At k+15 both toggle on the same edge.
- Edge cases:
  - D=1: tick constantly 1, sq toggles every cycle.
  - Write with cfg_ch=1 in an NCH=1 build: ignored.
  - Assert rst asynchronously between edges: outputs clear before the next edge.

Source files
------------

// File: rtl/div_freq_multi.sv
// Multi-channel clock divider: each channel emits a square wave with a programmable half-period
// and a single-cycle tick on every toggle. Divisors are shadowed so that reprogramming never
// produces a runt pulse.
module div_freq_multi #(
  parameter int unsigned NCH = 2,
  parameter int unsigned CW  = 28,
  parameter logic [NCH*CW-1:0] DIV_INIT = {28'd25_000_000, 28'd25_000},
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           sync,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  output logic [NCH-1:0] sq,
  output logic [NCH-1:0] tick
);

  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [CW-1:0]  act_q  [NCH];
  logic [CW-1:0]  act_d  [NCH];
  logic [CW-1:0]  pend_q [NCH];
  logic [CW-1:0]  pend_d [NCH];
  logic [NCH-1:0] sq_q, sq_d;
  logic [NCH-1:0] tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pend_d = pend_q;
    sq_d   = sq_q;
    tick_d = '0;
    for (int i = 0; i < NCH; i++) begin
      // Out-of-range channel numbers never match, so such writes are dropped.
      if (cfg_we && (int'(cfg_ch) == i)) begin
        pend_d[i] = cfg_div;
      end
      if (sync) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
        act_d[i] = pend_q[i];
      end else if (en) begin
        if (act_q[i] == '0) begin
          // Stopped channel keeps polling the shadow so a new divisor starts it at once.
          cnt_d[i] = '0;
          act_d[i] = pend_q[i];
        end else if (cnt_q[i] == act_q[i] - CW'(1)) begin
          cnt_d[i]  = '0;
          sq_d[i]   = ~sq_q[i];
          tick_d[i] = 1'b1;
          act_d[i]  = pend_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        act_q[i]  <= DIV_INIT[i*CW +: CW];
        pend_q[i] <= DIV_INIT[i*CW +: CW];
      end
      sq_q   <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      sq_q   <= sq_d;
      tick_q <= tick_d;
    end
  end

  assign sq   = sq_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_div_freq_multi.sv
// Bench for div_freq_multi: a two-channel build and a one-channel build checked every cycle
// against a half-period reference model, plus directed checks from the test plan.
module tb_div_freq_multi;

  logic       clk = 1'b0;
  logic       rst, en, sync;
  logic       cfg_we, cfg_ch, cfg_we1, cfg_ch1;
  logic [7:0] cfg_div;
  logic [1:0] sq, tick;
  logic [0:0] sq1, tick1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rec      = 1'b0;
  int t0q[$];
  int t1q[$];

  // Reference state: channels 0/1 belong to dut, channel 2 is the single channel of dut1.
  int m_el   [3];
  int m_per  [3];
  int m_pend [3];
  bit m_sq   [3];
  bit m_tk   [3];

  always #5 clk = ~clk;

  div_freq_multi #(.NCH(2), .CW(8), .DIV_INIT({8'd5, 8'd3})) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .sq(sq), .tick(tick)
  );

  div_freq_multi #(.NCH(1), .CW(8), .DIV_INIT(8'd3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we1), .cfg_ch(cfg_ch1),
    .cfg_div(cfg_div), .sq(sq1), .tick(tick1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_per[0] = 3; m_per[1] = 5; m_per[2] = 3;
    for (int c = 0; c < 3; c++) begin
      m_pend[c] = m_per[c];
      m_el[c]   = 0;
      m_sq[c]   = 1'b0;
      m_tk[c]   = 1'b0;
    end
  endtask

  // A channel with period P toggles after P counted cycles; a new period is adopted only
  // when a half-period ends, on sync, or while the channel is stopped.
  task automatic model_step();
    for (int c = 0; c < 3; c++) begin
      bit wr;
      int np;
      wr = (c < 2) ? (cfg_we && (int'(cfg_ch) == c)) : (cfg_we1 && (cfg_ch1 == 1'b0));
      np = wr ? int'(cfg_div) : m_pend[c];
      m_tk[c] = 1'b0;
      if (sync) begin
        m_el[c]  = 0;
        m_sq[c]  = 1'b0;
        m_per[c] = m_pend[c];
      end else if (en) begin
        if (m_per[c] == 0) begin
          m_per[c] = m_pend[c];
        end else if (m_el[c] + 1 == m_per[c]) begin
          m_el[c]  = 0;
          m_sq[c]  = ~m_sq[c];
          m_tk[c]  = 1'b1;
          m_per[c] = m_pend[c];
        end else begin
          m_el[c]++;
        end
      end
      m_pend[c] = np;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    chk("sq", 32'(sq), 32'({m_sq[1], m_sq[0]}));
    chk("tick", 32'(tick), 32'({m_tk[1], m_tk[0]}));
    chk("sq1", 32'(sq1), 32'(m_sq[2]));
    chk("tick1", 32'(tick1), 32'(m_tk[2]));
    if (rec && tick[0]) t0q.push_back(cyc);
    if (rec && tick[1]) t1q.push_back(cyc);
    cfg_we  = 1'b0;
    cfg_we1 = 1'b0;
    sync    = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sq", 32'({sq1, sq}), 32'd0);
    chk("arst_tick", 32'({tick1, tick}), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int e0[4] = '{3, 6, 13, 20};
    int e1[4] = '{5, 10, 15, 20};
    int n;
    int k;
    rst = 1'b1; en = 1'b1; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = 1'b0; cfg_we1 = 1'b0; cfg_ch1 = 1'b0; cfg_div = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sq", 32'({sq1, sq}), 32'd0);
    chk("rst_tick", 32'({tick1, tick}), 32'd0);
    rst = 1'b0;
    cyc = 0;
    rec = 1'b1;

    // Default divisors with a shadowed reprogram of ch0 to 7 at cycle 4.
    for (int c = 1; c <= 21; c++) begin
      if (c == 4) begin cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd7; end
      cycle();
    end
    rec = 1'b0;
    chk("t0_count", 32'(t0q.size()), 32'd4);
    chk("t1_count", 32'(t1q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t0_edge", 32'((t0q.size() > i) ? t0q[i] : -1), 32'(e0[i]));
      chk("t1_edge", 32'((t1q.size() > i) ? t1q[i] : -1), 32'(e1[i]));
    end

    // Stop ch1: it finishes the running half-period (ends at 25) and then stays quiet.
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd0;
    repeat (5) cycle();
    n = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      n += int'(tick[1]);
    end
    chk("dis_tick1", 32'(n), 32'd0);
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd2;
    repeat (9) cycle();

    // Global enable held low for 4 cycles: no ticks at all.
    en = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      n += int'(tick[0]) + int'(tick[1]) + int'(tick1[0]);
    end
    chk("en_tick", 32'(n), 32'd0);
    en = 1'b1;
    repeat (12) cycle();

    // Sync alignment with divisors 3 and 5.
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd3;
    cycle();
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd5;
    cycle();
    sync = 1'b1;
    cycle();
    k = cyc;
    chk("sync_sq", 32'(sq), 32'd0);
    while (cyc < k + 15) begin
      cycle();
      if (cyc == k + 3) chk("sync_k3", 32'(tick), 32'd1);
      if (cyc == k + 5) chk("sync_k5", 32'(tick), 32'd2);
    end
    chk("sync_k15", 32'(tick), 32'd3);

    // D=1 on ch0: tick held high, sq toggles every cycle.
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd1;
    cycle();
    sync = 1'b1;
    cycle();
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("d1_tick", 32'(tick[0]), 32'd1);
      chk("d1_sq", 32'(sq[0]), 32'(c % 2 == 0));
    end

    // Out-of-range channel write on the one-channel build must be dropped.
    cfg_we1 = 1'b1; cfg_ch1 = 1'b1; cfg_div = 8'd0;
    cycle();
    n = 0;
    for (int c = 0; c < 9; c++) begin
      cycle();
      n += int'(tick1[0]);
    end
    chk("oor_tick1", 32'(n), 32'd3);

    async_reset();

    // Randomised traffic against the model, with occasional asynchronous resets.
    for (int c = 0; c < 400; c++) begin
      en      = ($urandom_range(0, 7) != 0);
      sync    = ($urandom_range(0, 39) == 0);
      cfg_we  = ($urandom_range(0, 5) == 0);
      cfg_ch  = 1'($urandom_range(0, 1));
      cfg_we1 = ($urandom_range(0, 5) == 0);
      cfg_ch1 = 1'($urandom_range(0, 1));
      cfg_div = 8'($urandom_range(0, 6));
      cycle();
      if (c % 150 == 149) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
